// File: rtl/mem_stage.sv
// Memory-access stage: accepts from execute, holds the one-cycle SRAM read response
// across write-back stalls, aligns/extends loads and drives the MEM bypass.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_ready_go,
    output logic        allow_in,
    input  logic [31:0] exe_inst,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_alu_result,
    input  logic        exe_reg_en,
    input  logic        exe_mem_ld,
    input  logic [4:0]  exe_dest,
    input  logic [31:0] data_sram_rdata,
    output logic        ready_go,
    input  logic        wb_allow_in,
    output logic        valid,
    output logic [31:0] inst_mem,
    output logic [31:0] pc_mem,
    output logic [31:0] final_result,
    output logic        reg_en,
    output logic [4:0]  dest,
    output logic [31:0] forward_data_mem,
    output logic        forward_en_mem
);

    logic        valid_q, valid_d;
    logic        first_cyc_q, first_cyc_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] alu_q, alu_d;
    logic        reg_en_q, reg_en_d;
    logic        mem_ld_q, mem_ld_d;
    logic [4:0]  dest_q, dest_d;

    logic        fire_in;
    logic        fire_out;
    logic [31:0] rword;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign ready_go = valid_q;
    assign fire_out = ready_go & wb_allow_in;
    assign allow_in = ~valid_q | fire_out;
    assign fire_in  = exe_ready_go & allow_in;

    always_comb begin
        valid_d     = valid_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        alu_d       = alu_q;
        reg_en_d    = reg_en_q;
        mem_ld_d    = mem_ld_q;
        dest_d      = dest_q;
        first_cyc_d = fire_in;
        // Execute re-issues the read while we stall, so only the first response is trusted.
        rbuf_d      = first_cyc_q ? data_sram_rdata : rbuf_q;
        if (fire_in) begin
            valid_d  = 1'b1;
            inst_d   = exe_inst;
            pc_d     = exe_pc;
            alu_d    = exe_alu_result;
            reg_en_d = exe_reg_en;
            mem_ld_d = exe_mem_ld;
            dest_d   = exe_dest;
        end else if (fire_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            first_cyc_q <= 1'b0;
            rbuf_q      <= 32'h0;
            inst_q      <= 32'h0;
            pc_q        <= 32'h0;
            alu_q       <= 32'h0;
            reg_en_q    <= 1'b0;
            mem_ld_q    <= 1'b0;
            dest_q      <= 5'h0;
        end else begin
            valid_q     <= valid_d;
            first_cyc_q <= first_cyc_d;
            rbuf_q      <= rbuf_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            alu_q       <= alu_d;
            reg_en_q    <= reg_en_d;
            mem_ld_q    <= mem_ld_d;
            dest_q      <= dest_d;
        end
    end

    always_comb begin
        rword = first_cyc_q ? data_sram_rdata : rbuf_q;
        case (alu_q[1:0])
            2'd0:    ld_byte = rword[7:0];
            2'd1:    ld_byte = rword[15:8];
            2'd2:    ld_byte = rword[23:16];
            default: ld_byte = rword[31:24];
        endcase
        // Halfword select ignores addr[0]; misalignment is not trapped.
        ld_half = alu_q[1] ? rword[31:16] : rword[15:0];
        case (inst_q[31:22])
            10'h0A0: load_data = {{24{ld_byte[7]}}, ld_byte};
            10'h0A1: load_data = {{16{ld_half[15]}}, ld_half};
            10'h0A8: load_data = {24'h0, ld_byte};
            10'h0A9: load_data = {16'h0, ld_half};
            default: load_data = rword;
        endcase
    end

    assign valid            = valid_q;
    assign inst_mem         = inst_q;
    assign pc_mem           = pc_q;
    assign dest             = dest_q;
    assign reg_en           = valid_q & reg_en_q;
    assign final_result     = mem_ld_q ? load_data : alu_q;
    assign forward_data_mem = final_result;
    assign forward_en_mem   = valid_q & reg_en_q & (dest_q != 5'd0);

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: inputs driven 1ns after posedge,
// outputs sampled on negedge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_ready_go;
    logic        allow_in;
    logic [31:0] exe_inst;
    logic [31:0] exe_pc;
    logic [31:0] exe_alu_result;
    logic        exe_reg_en;
    logic        exe_mem_ld;
    logic [4:0]  exe_dest;
    logic [31:0] data_sram_rdata;
    logic        ready_go;
    logic        wb_allow_in;
    logic        valid;
    logic [31:0] inst_mem;
    logic [31:0] pc_mem;
    logic [31:0] final_result;
    logic        reg_en;
    logic [4:0]  dest;
    logic [31:0] forward_data_mem;
    logic        forward_en_mem;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0]  OP_LDB  = 10'h0A0;
    localparam logic [9:0]  OP_LDH  = 10'h0A1;
    localparam logic [9:0]  OP_LDW  = 10'h0A2;
    localparam logic [9:0]  OP_LDBU = 10'h0A8;
    localparam logic [9:0]  OP_LDHU = 10'h0A9;
    localparam logic [31:0] ADD_INST = 32'h00150C05;
    localparam logic [31:0] RWORD    = 32'h80FF7F01;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .exe_ready_go     (exe_ready_go),
        .allow_in         (allow_in),
        .exe_inst         (exe_inst),
        .exe_pc           (exe_pc),
        .exe_alu_result   (exe_alu_result),
        .exe_reg_en       (exe_reg_en),
        .exe_mem_ld       (exe_mem_ld),
        .exe_dest         (exe_dest),
        .data_sram_rdata  (data_sram_rdata),
        .ready_go         (ready_go),
        .wb_allow_in      (wb_allow_in),
        .valid            (valid),
        .inst_mem         (inst_mem),
        .pc_mem           (pc_mem),
        .final_result     (final_result),
        .reg_en           (reg_en),
        .dest             (dest),
        .forward_data_mem (forward_data_mem),
        .forward_en_mem   (forward_en_mem)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ld(input logic [9:0] op);
        return {op, 22'h012A5};
    endfunction

    // Presents one instruction; returns 1ns after the accepting edge.
    task automatic accept(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                          input logic ren, input logic ld, input logic [4:0] dst);
        exe_inst        = inst;
        exe_pc          = pc;
        exe_alu_result  = alu;
        exe_reg_en      = ren;
        exe_mem_ld      = ld;
        exe_dest        = dst;
        exe_ready_go    = 1'b1;
        data_sram_rdata = 32'h5555AAAA;
        @(negedge clk);
        check("acc_allow_in", {31'h0, allow_in}, 32'h1);
        tick();
        exe_ready_go = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [9:0] op, input logic [31:0] addr,
                           input logic [31:0] exp);
        wb_allow_in = 1'b1;
        accept(mk_ld(op), 32'h1C000100, addr, 1'b1, 1'b1, 5'd9);
        data_sram_rdata = RWORD;
        @(negedge clk);
        check(tag, final_result, exp);
        check({tag, "_fwd"}, forward_data_mem, exp);
        check({tag, "_fwd_en"}, {31'h0, forward_en_mem}, 32'h1);
        tick();
        data_sram_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        check({tag, "_left"}, {31'h0, valid}, 32'h0);
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        exe_ready_go    = 1'b0;
        exe_inst        = 32'h0;
        exe_pc          = 32'h0;
        exe_alu_result  = 32'h0;
        exe_reg_en      = 1'b0;
        exe_mem_ld      = 1'b0;
        exe_dest        = 5'h0;
        data_sram_rdata = 32'h0;
        wb_allow_in     = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_valid", {31'h0, valid}, 32'h0);
            check("rst_allow_in", {31'h0, allow_in}, 32'h1);
            check("rst_ready_go", {31'h0, ready_go}, 32'h0);
            check("rst_reg_en", {31'h0, reg_en}, 32'h0);
            check("rst_fwd_en", {31'h0, forward_en_mem}, 32'h0);
            check("rst_final", final_result, 32'h0);
            check("rst_pc", pc_mem, 32'h0);
            check("rst_inst", inst_mem, 32'h0);
            check("rst_dest", {27'h0, dest}, 32'h0);
            tick();
        end

        // Plain ALU op flows through in one cycle.
        accept(ADD_INST, 32'h1C000000, 32'h12345678, 1'b1, 1'b0, 5'd5);
        data_sram_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("add_final", final_result, 32'h12345678);
        check("add_reg_en", {31'h0, reg_en}, 32'h1);
        check("add_fwd_en", {31'h0, forward_en_mem}, 32'h1);
        check("add_fwd_data", forward_data_mem, 32'h12345678);
        check("add_ready_go", {31'h0, ready_go}, 32'h1);
        check("add_dest", {27'h0, dest}, 32'd5);
        check("add_pc", pc_mem, 32'h1C000000);
        check("add_inst", inst_mem, ADD_INST);
        tick();
        @(negedge clk);
        check("add_left", {31'h0, valid}, 32'h0);
        check("add_left_allow", {31'h0, allow_in}, 32'h1);
        tick();

        do_load("ldb_3",  OP_LDB,  32'h1003, 32'hFFFFFF80);
        do_load("ldbu_3", OP_LDBU, 32'h1003, 32'h00000080);
        do_load("ldh_2",  OP_LDH,  32'h1002, 32'hFFFF80FF);
        do_load("ldhu_0", OP_LDHU, 32'h1000, 32'h00007F01);
        do_load("ldw_0",  OP_LDW,  32'h1000, 32'h80FF7F01);
        do_load("ldb_1",  OP_LDB,  32'h1001, 32'h0000007F);
        do_load("ldb_2",  OP_LDB,  32'h1002, 32'hFFFFFFFF);
        do_load("ldbu_0", OP_LDBU, 32'h1000, 32'h00000001);
        do_load("ldh_3",  OP_LDH,  32'h1003, 32'hFFFF80FF);
        do_load("ldh_0",  OP_LDH,  32'h1000, 32'h00007F01);
        do_load("ldhu_2", OP_LDHU, 32'h1002, 32'h000080FF);
        do_load("ldw_3",  OP_LDW,  32'h1003, 32'h80FF7F01);
        do_load("ld_other", 10'h0A4, 32'h1001, 32'h80FF7F01);

        // Stall: first-cycle data must be held while the SRAM output changes.
        wb_allow_in = 1'b0;
        accept(mk_ld(OP_LDW), 32'h00000200, 32'h2000, 1'b1, 1'b1, 5'd7);
        data_sram_rdata = 32'h11223344;
        @(negedge clk);
        check("stall_first", final_result, 32'h11223344);
        check("stall_first_allow", {31'h0, allow_in}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            data_sram_rdata = 32'hDEADBEEF;
            exe_ready_go    = 1'b1;
            exe_pc          = 32'h00000999;
            exe_inst        = ADD_INST;
            exe_mem_ld      = 1'b0;
            @(negedge clk);
            check("stall_final", final_result, 32'h11223344);
            check("stall_allow_in", {31'h0, allow_in}, 32'h0);
            check("stall_valid", {31'h0, valid}, 32'h1);
            check("stall_pc", pc_mem, 32'h00000200);
        end
        tick();
        exe_ready_go = 1'b0;
        wb_allow_in  = 1'b1;
        @(negedge clk);
        check("stall_release_allow", {31'h0, allow_in}, 32'h1);
        check("stall_release_final", final_result, 32'h11223344);
        tick();
        @(negedge clk);
        check("stall_release_left", {31'h0, valid}, 32'h0);
        tick();

        // Back-to-back: add leaves while ld enters on the same edge.
        accept(ADD_INST, 32'h00000300, 32'hA5A5A5A5, 1'b1, 1'b0, 5'd3);
        exe_inst       = mk_ld(OP_LDW);
        exe_pc         = 32'h00000304;
        exe_alu_result = 32'h3000;
        exe_reg_en     = 1'b1;
        exe_mem_ld     = 1'b1;
        exe_dest       = 5'd4;
        exe_ready_go   = 1'b1;
        @(negedge clk);
        check("b2b_add_final", final_result, 32'hA5A5A5A5);
        check("b2b_allow_in", {31'h0, allow_in}, 32'h1);
        tick();
        exe_ready_go    = 1'b0;
        data_sram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("b2b_valid", {31'h0, valid}, 32'h1);
        check("b2b_pc", pc_mem, 32'h00000304);
        check("b2b_ld_final", final_result, 32'hCAFEF00D);
        check("b2b_dest", {27'h0, dest}, 32'd4);
        tick();
        @(negedge clk);
        check("b2b_left", {31'h0, valid}, 32'h0);
        tick();

        // dest 0 never forwards.
        accept(ADD_INST, 32'h00000400, 32'h00000042, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        check("r0_fwd_en", {31'h0, forward_en_mem}, 32'h0);
        check("r0_reg_en", {31'h0, reg_en}, 32'h1);
        check("r0_final", final_result, 32'h00000042);
        tick();

        // Reset during a stall drops the instruction.
        wb_allow_in = 1'b0;
        accept(mk_ld(OP_LDW), 32'h00000500, 32'h5000, 1'b1, 1'b1, 5'd8);
        data_sram_rdata = 32'h01020304;
        @(negedge clk);
        check("rststall_valid", {31'h0, valid}, 32'h1);
        tick();
        @(negedge clk);
        check("rststall_allow", {31'h0, allow_in}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rststall_valid_after", {31'h0, valid}, 32'h0);
        check("rststall_allow_after", {31'h0, allow_in}, 32'h1);
        check("rststall_final_after", final_result, 32'h0);
        check("rststall_pc_after", pc_mem, 32'h0);
        wb_allow_in = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline, sitting between the execute stage and write-back. It is the receiving end of the execute stage's valid/allow_in handshake and the consumer of the data SRAM read response issued from execute. It also aligns and sign/zero-extends loads, and holds SRAM read data stable while write-back stalls. It selects the write-back result and drives the MEM-stage bypass to decode.

## Interface
Parameters: none.

- clk  input  1  clock
- reset  input  1  synchronous, active-high reset; clock clk
- exe_ready_go  input  1  execute stage holds a valid instruction ready to pass
- allow_in  output  1  this stage can accept an instruction this cycle
- exe_inst  input  32  instruction word from execute
- exe_pc  input  32  PC from execute
- exe_alu_result  input  32  ALU result; for loads, the byte address
- exe_reg_en  input  1  instruction writes a GPR
- exe_mem_ld  input  1  instruction is a load
- exe_dest  input  5  destination GPR index
- data_sram_rdata  input  32  data SRAM read data, valid the cycle after the request
- ready_go  output  1  stage content may pass to write-back
- wb_allow_in  input  1  write-back can accept
- valid  output  1  stage holds a live instruction
- inst_mem  output  32  latched instruction
- pc_mem  output  32  latched PC
- final_result  output  32  load data (extended) or ALU result
- reg_en  output  1  GPR write enable, qualified by valid
- dest  output  5  destination GPR index
- forward_data_mem  output  32  bypass value, equal to final_result
- forward_en_mem  output  1  bypass usable: valid & reg_en & (dest != 0)

## Operation
- Accept: fire_in = exe_ready_go & allow_in. On fire_in, latch inst, pc, alu_result, reg_en, mem_ld and dest, and set valid to 1.
- Leave: fire_out = ready_go & wb_allow_in. When fire_out occurs and fire_in does not, valid clears to 0.
- ready_go = valid: the synchronous SRAM always responds in one cycle, so the stage adds no wait states.
- allow_in = ~valid | fire_out.
- Read-data hold: SRAM data is valid only in the first cycle after entry, because execute re-issues requests while this stage stalls.
  - State first_cyc is set on fire_in and cleared on the next clock.
  - rbuf captures data_sram_rdata at the end of the first_cyc cycle.
  - Effective word: rword = first_cyc ? data_sram_rdata : rbuf.
- Load decode uses latched inst[31:22]:
  - 0x0A0 ld.b: sign-extend byte
  - 0x0A1 ld.h: sign-extend half
  - 0x0A2 ld.w: full word
  - 0x0A8 ld.bu: zero-extend byte
  - 0x0A9 ld.hu: zero-extend half
  - Any other opcode with mem_ld = 1 is treated as ld.w.
- Byte select uses addr[1:0] = latched alu_result[1:0]: byte = rword[8*addr+7 : 8*addr].
- Half select uses addr[1] only: half = addr[1] ? rword[31:16] : rword[15:0]. addr[0] is ignored; misalignment is not trapped.
- ld.w ignores addr[1:0].
- final_result = mem_ld ? extended load data : alu_result.
- Non-load instructions never use rword.

## Timing
- Reset values: valid 0, first_cyc 0, rbuf 0, and all latched fields 0. Therefore:
  - allow_in = 1
  - ready_go = 0
  - reg_en = 0
  - forward_en_mem = 0
  - final_result = 0
  - inst_mem, pc_mem and dest are 0.
- Latency is one cycle per stage. An instruction accepted at edge N is presented to write-back during cycle N+1 and leaves at edge N+1 if wb_allow_in = 1.
- Simultaneous fire_in and fire_out: the new instruction replaces the old one, valid stays 1, and first_cyc is set again.
- Stall: while wb_allow_in = 0, all outputs stay constant, including final_result, even if data_sram_rdata changes.
- Reset mid-stall drops the held instruction. The next cycle shows allow_in = 1 and valid = 0.
- Bypass: forward_data_mem and forward_en_mem are combinational from latched state and rword. Load data is therefore forwardable in the same cycle it arrives.

## Test plan
- Reset, then idle: valid = 0, allow_in = 1, forward_en_mem = 0 and final_result = 0 for 3 cycles.
- add with ALU result 0x12345678, dest 5, wb_allow_in = 1: one cycle later final_result = 0x12345678, reg_en = 1 and forward_en_mem = 1; valid drops the following cycle.
- Loads of rword 0x80FF7F01:
  - ld.b, addr 0x1003 -> 0xFFFFFF80
  - ld.bu, addr 0x1003 -> 0x00000080
  - ld.h, addr 0x1002 -> 0xFFFF80FF
  - ld.hu, addr 0x1000 -> 0x00007F01
  - ld.w -> 0x80FF7F01
- ld.w with wb_allow_in = 0 for 4 cycles while data_sram_rdata changes to 0xDEADBEEF after the first cycle: final_result stays at the first-cycle value, allow_in = 0, and valid = 1 throughout.
- Back-to-back add then ld with wb_allow_in = 1: fire_in and fire_out coincide, and final_result switches to the load data in the next cycle.
- Instruction with dest = 0 and reg_en = 1: forward_en_mem = 0.
- Reset asserted during a stall: valid = 0 and allow_in = 1 on the following cycle.
